perceptron_mac: RTL and testbench

PERCEPTRON_MAC -- requirements
Module: perceptron_mac

---
 rtl/perceptron_mac.sv | 175 +++++++++++++++++
 tb/tb_perceptron_mac.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/perceptron_mac.sv
`default_nettype none
// ============================================================================
// Module   : perceptron_mac
// Function : Single-neuron perceptron. Weighted sum of N signed pairs plus a
//            bias, one MAC per cycle, then a selectable activation function.
// Revision : 1.0 - initial release
// ============================================================================

module perceptron_mac #(
    parameter int N_INPUTS = 4,
    parameter int DATA_W   = 8,
    localparam int ACC_W   = 2*DATA_W + $clog2(N_INPUTS+1)
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [N_INPUTS*DATA_W-1:0] weights,
    input  logic [N_INPUTS*DATA_W-1:0] values,
    input  logic [DATA_W-1:0]          bias,
    input  logic [1:0]                 activation,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic signed [ACC_W-1:0]    prediction,
    output logic                       fire
);

    localparam int IDX_W  = (N_INPUTS > 1) ? $clog2(N_INPUTS) : 1;
    localparam int PROD_W = 2*DATA_W;
    localparam int EXT_W  = ACC_W - PROD_W;

    localparam logic [1:0] ACT_RELU  = 2'd0;
    localparam logic [1:0] ACT_STEP  = 2'd1;
    localparam logic [1:0] ACT_IDENT = 2'd2;
    localparam logic [1:0] ACT_LEAKY = 2'd3;

    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_INPUTS-1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MAC  = 2'd1,
        S_ACT  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t                      r_state;
    state_t                      w_state_nxt;

    logic [N_INPUTS*DATA_W-1:0]  r_weights;
    logic [N_INPUTS*DATA_W-1:0]  r_values;
    logic [1:0]                  r_act;
    logic signed [ACC_W-1:0]     r_acc;
    logic [IDX_W-1:0]            r_idx;

    logic signed [DATA_W-1:0]    w_w [N_INPUTS];
    logic signed [DATA_W-1:0]    w_v [N_INPUTS];
    logic signed [DATA_W-1:0]    w_wsel;
    logic signed [DATA_W-1:0]    w_vsel;
    logic signed [PROD_W-1:0]    w_prod;
    logic signed [ACC_W-1:0]     w_prod_ext;
    logic signed [ACC_W-1:0]     w_bias_ext;
    logic                        w_accept;
    logic                        w_pos;
    logic signed [ACC_W-1:0]     w_pred;

    generate
        for (genvar gi = 0; gi < N_INPUTS; gi++) begin : g_unpack
            assign w_w[gi] = r_weights[gi*DATA_W +: DATA_W];
            assign w_v[gi] = r_values[gi*DATA_W +: DATA_W];
        end
    endgenerate

    assign w_wsel     = w_w[r_idx];
    assign w_vsel     = w_v[r_idx];
    assign w_prod     = w_wsel * w_vsel;
    assign w_prod_ext = {{EXT_W{w_prod[PROD_W-1]}}, w_prod};
    assign w_bias_ext = {{(ACC_W-DATA_W){bias[DATA_W-1]}}, bias};
    assign w_accept   = in_valid && in_ready;

    // Strictly positive: sign clear and not zero.
    assign w_pos = !r_acc[ACC_W-1] && (r_acc != '0);

    always_comb begin
        w_pred = r_acc;
        case (r_act)
            ACT_RELU:  w_pred = w_pos ? r_acc : '0;
            ACT_STEP:  w_pred = {{(ACC_W-1){1'b0}}, w_pos};
            ACT_IDENT: w_pred = r_acc;
            ACT_LEAKY: w_pred = r_acc[ACC_W-1] ? (r_acc >>> 3) : r_acc;
            default:   w_pred = r_acc;
        endcase
    end

    always_comb begin
        w_state_nxt = r_state;
        in_ready    = 1'b0;
        case (r_state)
            S_IDLE: begin
                in_ready = rst_n;
                if (in_valid) begin
                    w_state_nxt = S_MAC;
                end
            end
            S_MAC: begin
                if (r_idx == IDX_LAST) begin
                    w_state_nxt = S_ACT;
                end
            end
            S_ACT: begin
                w_state_nxt = S_DONE;
            end
            S_DONE: begin
                if (out_ready) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_weights  <= '0;
            r_values   <= '0;
            r_act      <= '0;
            r_acc      <= '0;
            r_idx      <= '0;
            prediction <= '0;
            fire       <= 1'b0;
            out_valid  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_weights <= weights;
                        r_values  <= values;
                        r_act     <= activation;
                        r_acc     <= w_bias_ext;
                        r_idx     <= '0;
                    end
                end
                S_MAC: begin
                    r_acc <= r_acc + w_prod_ext;
                    r_idx <= r_idx + 1'b1;
                end
                S_ACT: begin
                    prediction <= w_pred;
                    fire       <= w_pos;
                    out_valid  <= 1'b1;
                end
                S_DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_perceptron_mac.sv
`default_nettype none
// ============================================================================
// Module   : tb_perceptron_mac
// Function : Scoreboard bench for perceptron_mac (N_INPUTS=2, DATA_W=8).
// Revision : 1.0 - initial release
// ============================================================================

module tb_perceptron_mac;

    localparam int N     = 2;
    localparam int DW    = 8;
    localparam int AW    = 18;
    localparam int LAT   = N + 1;

    logic                   clk;
    logic                   rst_n;
    logic                   in_valid;
    logic                   in_ready;
    logic [N*DW-1:0]        weights;
    logic [N*DW-1:0]        values;
    logic [DW-1:0]          bias;
    logic [1:0]             activation;
    logic                   out_valid;
    logic                   out_ready;
    logic signed [AW-1:0]   prediction;
    logic                   fire;

    typedef struct {
        int pred;
        int fire;
    } exp_t;

    exp_t q_exp[$];
    int   n_cmp;
    int   n_err;

    perceptron_mac #(
        .N_INPUTS (N),
        .DATA_W   (DW)
    ) u_dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .weights    (weights),
        .values     (values),
        .bias       (bias),
        .activation (activation),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .prediction (prediction),
        .fire       (fire)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input int obs, input int exp_v);
        n_cmp++;
        if (obs !== exp_v) begin
            n_err++;
            $display("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
        end
    endtask

    function automatic exp_t model(input int w0, input int w1, input int v0,
                                   input int v1, input int b, input int act);
        exp_t r;
        int   acc;
        acc    = b + w0*v0 + w1*v1;
        r.fire = (acc > 0) ? 1 : 0;
        case (act)
            0:       r.pred = (acc > 0) ? acc : 0;
            1:       r.pred = (acc > 0) ? 1 : 0;
            2:       r.pred = acc;
            default: r.pred = (acc >= 0) ? acc : (acc >>> 3);
        endcase
        return r;
    endfunction

    // Drives one operand set with in_valid high and records its expected result.
    task automatic start_txn(input int w0, input int w1, input int v0,
                             input int v1, input int b, input int act);
        logic [DW-1:0] t_w0, t_w1, t_v0, t_v1, t_b;
        t_w0 = w0[DW-1:0];
        t_w1 = w1[DW-1:0];
        t_v0 = v0[DW-1:0];
        t_v1 = v1[DW-1:0];
        t_b  = b[DW-1:0];
        weights    = {t_w1, t_w0};
        values     = {t_v1, t_v0};
        bias       = t_b;
        activation = act[1:0];
        in_valid   = 1'b1;
        q_exp.push_back(model(w0, w1, v0, v1, b, act));
    endtask

    // Waits for out_valid; in_valid is dropped after acc_edges edges, and the
    // edge count to out_valid must be acc_edges + LAT.
    task automatic wait_result(input string tag, input int acc_edges);
        int   edges;
        exp_t e;
        edges = 0;
        while (edges < 20) begin
            @(posedge clk);
            #1;
            edges++;
            if (edges == acc_edges) in_valid = 1'b0;
            if (out_valid) break;
        end
        check({tag, "_latency"}, edges, acc_edges + LAT);
        if (q_exp.size() == 0) begin
            check({tag, "_sb_empty"}, 0, 1);
        end else begin
            e = q_exp.pop_front();
            check({tag, "_pred"}, prediction, e.pred);
            check({tag, "_fire"}, fire, e.fire);
            check({tag, "_in_ready_done"}, in_ready, 0);
        end
    endtask

    initial begin
        n_cmp      = 0;
        n_err      = 0;
        rst_n      = 1'b0;
        in_valid   = 1'b0;
        out_ready  = 1'b1;
        weights    = '0;
        values     = '0;
        bias       = '0;
        activation = '0;

        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready", in_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_pred", prediction, 0);
        check("rst_fire", fire, 0);
        rst_n = 1'b1;
        #1;
        check("idle_in_ready", in_ready, 1);

        start_txn(1, 1, 1, 1, 1, 0);
        wait_result("relu_pos", 1);

        // Each following set is presented while DONE is still showing the
        // previous result, so it is only taken on the edge after returning.
        start_txn(-4, 2, 3, 1, 0, 0);
        wait_result("relu_neg", 2);
        start_txn(-4, 2, 3, 1, 0, 1);
        wait_result("step_neg", 2);
        start_txn(-4, 2, 3, 1, 0, 2);
        wait_result("ident_neg", 2);
        start_txn(-4, 2, 3, 1, 0, 3);
        wait_result("leaky_neg", 2);
        start_txn(-128, -128, -128, -128, 127, 2);
        wait_result("ident_max", 2);

        @(posedge clk);
        #1;
        check("back_idle", in_ready, 1);

        out_ready = 1'b0;
        start_txn(1, 1, 1, 1, 1, 0);
        wait_result("stall", 1);
        for (int i = 0; i < 5; i++) begin
            in_valid = (i % 2 == 0);
            weights  = 16'($urandom);
            values   = 16'($urandom);
            @(posedge clk);
            #1;
            check("stall_out_valid", out_valid, 1);
            check("stall_pred", prediction, 3);
            check("stall_fire", fire, 1);
            check("stall_in_ready", in_ready, 0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("release_out_valid", out_valid, 0);
        check("release_in_ready", in_ready, 1);
        check("release_pred_kept", prediction, 3);
        check("release_fire_kept", fire, 1);

        start_txn(1, 2, 3, 4, 0, 2);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("midrst_out_valid", out_valid, 0);
        check("midrst_pred", prediction, 0);
        check("midrst_fire", fire, 0);
        check("midrst_in_ready", in_ready, 0);
        q_exp.delete();
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            check("inrst_out_valid", out_valid, 0);
        end
        rst_n = 1'b1;
        start_txn(2, 3, 5, -1, -1, 0);
        wait_result("post_rst", 1);

        check("sb_drained", q_exp.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
